// File: rtl/mmio_responder.sv
// Memory-mapped responder for an 8-word window on the data bus.
// It provides the hex/LED registers, synchronized switches, a down-counter timer and a cycle counter.
//
// state | meaning
// IDLE  | timer disabled, count and prescaler hold
// RUN   | timer enabled, prescaler ticks the count down toward expiry
module mmio_responder #(
  parameter logic [15:0] BASE     = 16'hFF00,
  parameter int          PRESCALE = 1
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic        Wr,
  input  logic [15:0] sw,
  output logic [15:0] q,
  output logic        hit,
  output logic [31:0] hex_value,
  output logic [15:0] ledr
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tmr_state_e;

  tmr_state_e    state_q, state_d;
  logic [15:0]   rd_q, rd_d;
  logic          hit_q, hit_d;
  logic [15:0]   hex_lo_q, hex_lo_d, hex_hi_q, hex_hi_d, ledr_q, ledr_d;
  logic [15:0]   sw_s1_q, sw_s2_q;
  logic [15:0]   load_q, load_d, count_q, count_d, cycle_q, cycle_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          auto_q, auto_d, expired_q, expired_d;

  logic          in_win, wr_en, expire;
  logic [2:0]    off;
  logic [15:0]   rdata;

  always_comb begin
    in_win    = (addr[15:3] == BASE[15:3]);
    off       = addr[2:0];
    wr_en     = Wr && in_win;
    expire    = 1'b0;
    state_d   = state_q;
    hex_lo_d  = hex_lo_q;
    hex_hi_d  = hex_hi_q;
    ledr_d    = ledr_q;
    load_d    = load_q;
    count_d   = count_q;
    presc_d   = presc_q;
    auto_d    = auto_q;
    expired_d = expired_q;
    cycle_d   = cycle_q + 16'd1;

    if (state_q == RUN) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        if (count_q != 16'd0) begin
          count_d = count_q - 16'd1;
        end else begin
          expire = 1'b1;
          if (auto_q) begin
            count_d = load_q;
          end else begin
            state_d = IDLE;
            count_d = 16'd0;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // Bus writes take precedence over the timer's own count/enable update.
    if (wr_en) begin
      case (off)
        3'd0: hex_lo_d = data;
        3'd1: hex_hi_d = data;
        3'd2: ledr_d   = data;
        3'd4: begin
          load_d  = data;
          count_d = data;
          presc_d = '0;
          state_d = state_q;
        end
        3'd5: begin
          state_d = data[0] ? RUN : IDLE;
          auto_d  = data[1];
          count_d = count_q;
          if (data[0] && (state_q == IDLE)) presc_d = '0;
          if (data[15]) expired_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (expire) expired_d = 1'b1;

    case (off)
      3'd0:    rdata = hex_lo_q;
      3'd1:    rdata = hex_hi_q;
      3'd2:    rdata = ledr_q;
      3'd3:    rdata = sw_s2_q;
      3'd4:    rdata = load_q;
      3'd5:    rdata = {expired_q, 13'd0, auto_q, state_q == RUN};
      3'd6:    rdata = count_q;
      default: rdata = cycle_q;
    endcase
    rd_d  = in_win ? rdata : 16'd0;
    hit_d = in_win;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      hit_q     <= 1'b0;
      hex_lo_q  <= '0;
      hex_hi_q  <= '0;
      ledr_q    <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      load_q    <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      cycle_q   <= '0;
      auto_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      hit_q     <= hit_d;
      hex_lo_q  <= hex_lo_d;
      hex_hi_q  <= hex_hi_d;
      ledr_q    <= ledr_d;
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      load_q    <= load_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      cycle_q   <= cycle_d;
      auto_q    <= auto_d;
      expired_q <= expired_d;
    end
  end

  assign q         = rd_q;
  assign hit       = hit_q;
  assign hex_value = {hex_hi_q, hex_lo_q};
  assign ledr      = ledr_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: two builds (PRESCALE 1 and 4) share one bus,
// read expectations go through a scoreboard queue and are checked one edge later.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0, data = '0, sw = '0;
  logic        Wr = 1'b0;
  logic [15:0] q1, q2, ledr1, ledr2;
  logic        hit1, hit2;
  logic [31:0] hex1, hex2;
  logic [15:0] tb_cyc;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] q;
    logic        hit;
    logic        dut;
  } exp_t;
  exp_t  sb[$];
  string tq[$];

  mmio_responder #(.BASE(16'hFF00), .PRESCALE(1)) u_p1 (
    .Clock(clk), .Resetn(rst_n), .addr(addr), .data(data), .Wr(Wr), .sw(sw),
    .q(q1), .hit(hit1), .hex_value(hex1), .ledr(ledr1));

  mmio_responder #(.BASE(16'hFF00), .PRESCALE(4)) u_p4 (
    .Clock(clk), .Resetn(rst_n), .addr(addr), .data(data), .Wr(Wr), .sw(sw),
    .q(q2), .hit(hit2), .hex_value(hex2), .ledr(ledr2));

  always #5 clk = ~clk;

  // Edges since reset release: what CYCLE holds just before the next edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 16'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_x(input logic [15:0] a, input logic [15:0] exp, input bit use_cyc,
                      input bit dut, input string tag);
    exp_t e, o;
    string t;
    @(negedge clk);
    Wr   = 1'b0;
    addr = a;
    e.q   = use_cyc ? tb_cyc : exp;
    e.hit = (a[15:3] == 13'h1FE0);
    e.dut = dut;
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    t = tq.pop_front();
    chk({t, "_q"},   o.dut ? q2 : q1, {16'd0, o.q});
    chk({t, "_hit"}, o.dut ? hit2 : hit1, {31'd0, o.hit});
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    rd_x(a, exp, 1'b0, 1'b0, tag);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a;
    data = d;
    Wr   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      Wr   = 1'b0;
      addr = 16'h0000;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q1, 0);
    chk("rst_hit", hit1, 0);
    chk("rst_hex", hex1, 0);
    chk("rst_ledr", ledr1, 0);
    chk("rst_hex_p4", hex2, 0);
    chk("rst_ledr_p4", ledr2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    rd(16'hFF00, 16'h0000, "rst_hexlo");
    rd(16'hFF01, 16'h0000, "rst_hexhi");
    rd(16'hFF02, 16'h0000, "rst_ledr_rd");
    rd(16'hFF03, 16'h0000, "rst_sw");
    rd(16'hFF04, 16'h0000, "rst_load");
    rd(16'hFF05, 16'h0000, "rst_ctrl");
    rd(16'hFF06, 16'h0000, "rst_count");
    rd_x(16'hFF07, 16'h0000, 1'b1, 1'b0, "rst_cycle");
    rd(16'h0010, 16'h0000, "out_of_win");

    wr(16'hFF00, 16'h1234);
    wr(16'hFF01, 16'hABCD);
    chk("hex_value", hex1, 32'hABCD1234);
    wr(16'hFF02, 16'h00FF);
    chk("ledr", ledr1, 16'h00FF);
    rd(16'hFF00, 16'h1234, "rb_hexlo");
    rd(16'hFF01, 16'hABCD, "rb_hexhi");
    rd(16'hFF02, 16'h00FF, "rb_ledr");
    wr(16'hFF03, 16'h5555);
    rd(16'hFF03, 16'h0000, "ro_sw");
    wr(16'hFF06, 16'h7777);
    rd(16'hFF06, 16'h0000, "ro_count");
    wr(16'hFF07, 16'h1234);
    rd_x(16'hFF07, 16'h0000, 1'b1, 1'b0, "ro_cycle");
    wr(16'hFEF8, 16'h0BAD);
    wr(16'hFF08, 16'h0BAD);
    rd(16'hFF00, 16'h1234, "outwr_hexlo");
    chk("outwr_ledr", ledr1, 16'h00FF);
    rd(16'hFF08, 16'h0000, "above_win");

    // One-shot, PRESCALE=1
    wr(16'hFF04, 16'd3);
    wr(16'hFF05, 16'h0001);
    rd(16'hFF06, 16'd3, "os_cnt3");
    rd(16'hFF06, 16'd2, "os_cnt2");
    rd(16'hFF06, 16'd1, "os_cnt1");
    rd(16'hFF06, 16'd0, "os_cnt0");
    rd(16'hFF05, 16'h8000, "os_expired");
    rd(16'hFF06, 16'd0, "os_hold0");
    wr(16'hFF05, 16'h8000);
    rd(16'hFF05, 16'h0000, "os_w1c");

    // Auto-reload
    wr(16'hFF04, 16'd2);
    wr(16'hFF05, 16'h0003);
    rd(16'hFF06, 16'd2, "ar_c2a");
    rd(16'hFF06, 16'd1, "ar_c1a");
    rd(16'hFF06, 16'd0, "ar_c0a");
    rd(16'hFF06, 16'd2, "ar_c2b");
    rd(16'hFF06, 16'd1, "ar_c1b");
    rd(16'hFF06, 16'd0, "ar_c0b");
    rd(16'hFF06, 16'd2, "ar_c2c");
    rd(16'hFF05, 16'h8003, "ar_sticky");
    wr(16'hFF05, 16'h8003);
    rd(16'hFF05, 16'h8003, "ar_set_beats_clr");
    wr(16'hFF05, 16'h8000);
    rd(16'hFF05, 16'h0000, "ar_stop");

    // Switch synchronizer latency
    sw = 16'h5A5A;
    rd(16'hFF03, 16'h0000, "sw_edge1");
    rd(16'hFF03, 16'h0000, "sw_edge2");
    rd(16'hFF03, 16'h5A5A, "sw_edge3");

    // Reset mid-countdown
    wr(16'hFF00, 16'h1111);
    wr(16'hFF04, 16'd5);
    wr(16'hFF05, 16'h0001);
    idle(2);
    rd(16'hFF06, 16'd3, "pre_rst_cnt");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", q1, 0);
    chk("arst_hit", hit1, 0);
    chk("arst_hex", hex1, 0);
    chk("arst_ledr", ledr1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rd(16'hFF06, 16'h0000, "post_rst_cnt");
    rd(16'hFF05, 16'h0000, "post_rst_ctrl");
    rd(16'hFF04, 16'h0000, "post_rst_load");
    rd(16'hFF00, 16'h0000, "post_rst_hexlo");

    // PRESCALE=4: LOAD=1 expires 8 edges after enable
    wr(16'hFF04, 16'd1);
    wr(16'hFF05, 16'h0001);
    idle(7);
    rd_x(16'hFF05, 16'h0001, 1'b0, 1'b1, "p4_not_yet");
    rd_x(16'hFF05, 16'h8000, 1'b0, 1'b1, "p4_expired");
    rd_x(16'hFF06, 16'h0000, 1'b0, 1'b1, "p4_count");
    rd(16'hFF05, 16'h8000, "p1_same_load");

    // CYCLE wrap
    for (int i = 0; i < 70000; i++) begin
      if (tb_cyc == 16'hFFFF) break;
      idle(1);
    end
    if (tb_cyc !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL cycle_budget observed=%h expected=ffff", tb_cyc);
    end
    rd(16'hFF07, 16'hFFFF, "cyc_ffff");
    rd(16'hFF07, 16'h0000, "cyc_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the processor's data bus, the target-side counterpart of the processor's bus-initiator port. It decodes an 8-word window, serves register reads with the same one-cycle latency as the synchronous memory, and drives the 7-segment value, LEDs and a programmable down-counter timer. The top level muxes `q` against memory read data using `hit`.

## Interface
Parameters:
- `BASE`, 16'hFF00, window base address; bits [2:0] must be 0.
- `PRESCALE`, 1, clock cycles per timer tick (≥1).

Ports:
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `addr`  in  16  bus address from the processor.
- `data`  in  16  bus write data from the processor.
- `Wr`  in  1  write strobe; the write happens at the rising edge where `Wr`=1 and the address is in the window.
- `sw`  in  16  raw switch inputs, asynchronous.
- `q`  out  16  registered read data.
- `hit`  out  1  registered; 1 when the previous cycle's `addr` was in the window.
- `hex_value`  out  32  value for the eight 7-segment decoders.
- `ledr`  out  16  LED register.

## Operation
- In window when `addr[15:3]==BASE[15:3]`. The offset is `addr[2:0]`.
- Register map:
  - +0 HEX_LO RW → `hex_value[15:0]`
  - +1 HEX_HI RW → `hex_value[31:16]`
  - +2 LEDR RW
  - +3 SW RO, a 2-flop synchronized copy of `sw`
  - +4 TMR_LOAD RW
  - +5 TMR_CTRL, laid out as {expired, 13'b0, auto, enable}
  - +6 TMR_COUNT RO
  - +7 CYCLE RO
- Writes to RO offsets are ignored. Writes outside the window are ignored entirely.
- TMR_CTRL write:
  - bits [1:0] are stored.
  - bit15=1 clears `expired` (write-one-to-clear).
  - A write with enable 0→1 restarts the prescaler at 0.
- TMR_LOAD write stores the reload value and also loads the count. It restarts the prescaler.
- CYCLE: free-running 16-bit counter, +1 every cycle, wraps FFFF→0000.
- Timer FSM:
  - IDLE (enable=0): count and prescaler hold.
  - RUN (enable=1): the prescaler counts 0..PRESCALE-1. A tick occurs when it equals PRESCALE-1, and the prescaler then wraps to 0.
  - On a tick with count≠0: count−1.
  - On a tick with count==0: `expired`←1. If auto=1, count←TMR_LOAD and the FSM stays in RUN. If auto=0, enable←0 and the FSM returns to IDLE with count 0.
- Same-cycle conflicts:
  - A bus write to TMR_LOAD or TMR_CTRL overrides the timer's own update of count and enable in that cycle.
  - `expired` set beats a W1C clear in the same cycle.

## Timing
- Reset (Resetn=0, asynchronous): q, hit, hex_value, ledr, TMR_LOAD, count, prescaler, CYCLE, sync flops, enable, auto and expired are all 0. The FSM is in IDLE.
- Reset mid-countdown aborts immediately; no tick is lost or emitted after release.
- Read latency: 1 cycle. `q` and `hit` at edge N+1 reflect `addr` presented before edge N+1.
  - Out of window: q=0 and hit=0.
  - Read data is the register value before any same-edge write, i.e. read-before-write.
  - CYCLE reads return the value before that edge's increment.
- SW path: a change on `sw` is visible in a read issued 2 edges later, so `q` shows it on the 3rd edge.
- Write effect: the RW register shows the new value at the output one edge after the write edge (`hex_value`, `ledr` update at the write edge itself).
- With PRESCALE=1 and load L, enable at edge E: expired sets at edge E+L+1.

## Test plan
- Reset, then read +0..+7: all return 0000 except CYCLE; hit=1 one cycle after each read; read 0x0010 → hit=0, q=0.
- Write 16'h1234 to +0, 16'hABCD to +1, 16'h00FF to +2 → hex_value=32'hABCD1234, ledr=00FF; read back matches; write to +3/+6/+7 ignored.
- PRESCALE=1: LOAD=3, CTRL=0001 → COUNT reads 3,2,1,0; expired sets 4 edges after the enable edge; enable clears; CTRL reads 8000; write 8000 → CTRL reads 0000.
- Auto-reload: LOAD=2, CTRL=0003 → count 2,1,0,2,1,0… with expired sticky; a W1C on the same edge as expiry leaves expired=1.
- sw=16'h5A5A changes → SW read returns 5A5A no earlier than 3 edges after the change; Resetn pulsed low mid-countdown → all outputs 0 immediately, timer IDLE after release.
- CYCLE wrap: run 65536 cycles after reset → reads wrap FFFF→0000; PRESCALE=4 build: LOAD=1 → expiry after 8 enabled cycles.
